// File: rtl/inst_data_axi_bridge.sv
// rtl/inst_data_axi_bridge.sv - SRAM-like inst/data ports to a single AXI master, one transaction at a time
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_*                      instruction fetch port (read only)
//   data_*                      load/store port, data has grant priority
//   ar*/r*                      AXI read address / read data channels
//   aw*/w*/b*                   AXI write address / write data / write response channels
module inst_data_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW_W = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        owner_data_q, owner_data_d;  // 1 = data port owns the transaction
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        idle;
  logic        aw_fin;
  logic        w_fin;
  logic        r_beat;
  logic [3:0]  strb_calc;

  // addr_ok is combinational on the request; gating with resetn keeps it low
  // while reset is held even though state already reads IDLE.
  assign idle         = (state_q == ST_IDLE) & resetn;
  assign data_addr_ok = idle & data_req;
  assign inst_addr_ok = idle & inst_req & ~data_req;

  assign arvalid = (state_q == ST_AR);
  assign araddr  = addr_q;
  assign rready  = (state_q == ST_R);
  assign awaddr  = addr_q;
  assign awvalid = (state_q == ST_AW_W) & ~aw_done_q;
  assign wvalid  = (state_q == ST_AW_W) & ~w_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = (state_q == ST_B);

  assign r_beat       = (state_q == ST_R) & rvalid;
  assign inst_data_ok = r_beat & ~owner_data_q;
  assign data_data_ok = (r_beat & owner_data_q) | ((state_q == ST_B) & bvalid);
  assign inst_rdata   = inst_data_ok ? rdata : 32'd0;
  assign data_rdata   = (r_beat & owner_data_q) ? rdata : 32'd0;

  // Each channel is done once it has handshaken now or in an earlier cycle.
  assign aw_fin = aw_done_q | (awvalid & awready);
  assign w_fin  = w_done_q | (wvalid & wready);

  always_comb begin
    strb_calc = 4'b1111;
    case (data_size)
      2'd0:    strb_calc = 4'b0001 << data_addr[1:0];
      2'd1:    strb_calc = 4'b0011 << {data_addr[1], 1'b0};
      default: strb_calc = 4'b1111;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    case (state_q)
      ST_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (data_req) begin
          owner_data_d = 1'b1;
          addr_d       = data_addr;
          wdata_d      = data_wdata;
          wstrb_d      = strb_calc;
          state_d      = data_wr ? ST_AW_W : ST_AR;
        end else if (inst_req) begin
          owner_data_d = 1'b0;
          addr_d       = inst_addr;
          wdata_d      = 32'd0;
          wstrb_d      = 4'b1111;
          state_d      = ST_AR;
        end
      end
      ST_AR: begin
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        if (rvalid) state_d = ST_IDLE;
      end
      ST_AW_W: begin
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) state_d = ST_B;
      end
      ST_B: begin
        if (bvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_data_q <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

endmodule
